// File: rtl/pipe_hazard_ctrl_pkg.sv
// Purpose: shared types for the pipeline stall/flush sequencer (FSM states, stage-enable bundle).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MUL_BUSY = 2'd2,
        HALT     = 2'd3
    } ctrl_state_t;

    localparam int DEF_MUL_LATENCY = 4;
    localparam int DEF_CNT_W       = 32;

    // One enable per pipeline register, PC first.
    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
    } stage_en_t;

    localparam stage_en_t EN_ALL  = '{pc: 1'b1, if_id: 1'b1, id_ex: 1'b1, ex_mem: 1'b1, mem_wb: 1'b1};
    localparam stage_en_t EN_NONE = '{pc: 1'b0, if_id: 1'b0, id_ex: 1'b0, ex_mem: 1'b0, mem_wb: 1'b0};
    // Front end frozen, EX held by the multiplier, a bubble drains into MEM.
    localparam stage_en_t EN_MUL  = '{pc: 1'b0, if_id: 1'b0, id_ex: 1'b0, ex_mem: 1'b1, mem_wb: 1'b1};
    // IF/ID held, a bubble goes into EX behind the load.
    localparam stage_en_t EN_LDU  = '{pc: 1'b0, if_id: 1'b0, id_ex: 1'b1, ex_mem: 1'b1, mem_wb: 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Purpose: hazard requests in, stage controls and perf counters out.
// Latency: n/a (wires only). master = pipeline side, slave = sequencer side.
// Backpressure: n/a; stalls are expressed through the enables carried here.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    // Hazard requests from the stages.
    logic             d_hazard_detected;
    logic             ex_take_branch;
    logic             ex_mul_start;
    logic             mem_req;
    logic             mem_ready;
    logic             wb_halt;
    // Controls back to the pipeline.
    logic             pc_en;
    logic             pc_sel_target;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_mem_bubble;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output d_hazard_detected, ex_take_branch, ex_mul_start, mem_req, mem_ready, wb_halt,
        input  pc_en, pc_sel_target, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_bubble, ex_mem_bubble, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  d_hazard_detected, ex_take_branch, ex_mul_start, mem_req, mem_ready, wb_halt,
        output pc_en, pc_sel_target, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_bubble, ex_mem_bubble, halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Purpose: saturating event counter (clk, rst_n, inc_i -> count_o), sticks at all-ones.
// Latency: count_o reflects inc_i one clock later.
// Backpressure: none; counts every cycle inc_i is high.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !(&count_q)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: central stall/flush sequencer for the 5-stage pipeline; ports clk, rst (async active-low), hz (slave).
// Latency: controls are combinational from state+requests; state and counters update on the next clock.
// Backpressure: memory not-ready freezes every stage; MUL freezes the front end for MUL_LATENCY-1 cycles.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = DEF_MUL_LATENCY,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);
    localparam int              MC_W       = $clog2(MUL_LATENCY) + 1;
    localparam bit              MUL_STALLS = (MUL_LATENCY > 1);
    // The issue cycle is itself the first stall cycle, so the counter starts two short.
    localparam logic [MC_W-1:0] MUL_INIT   = MC_W'((MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0);

    ctrl_state_t     state_q, state_d;
    logic [MC_W-1:0] mul_cnt_q, mul_cnt_d;

    stage_en_t en;
    logic      sel_target;
    logic      flush;
    logic      id_bubble;
    logic      ex_bubble;
    logic      apply_rules;
    logic      mul_allowed;
    logic      mem_stall;

    assign mem_stall = hz.mem_req && !hz.mem_ready;

    always_comb begin
        en          = EN_ALL;
        sel_target  = 1'b0;
        flush       = 1'b0;
        id_bubble   = 1'b0;
        ex_bubble   = 1'b0;
        state_d     = state_q;
        mul_cnt_d   = mul_cnt_q;
        apply_rules = 1'b0;
        mul_allowed = 1'b0;

        case (state_q)
            RUN: begin
                if (hz.wb_halt) begin
                    en      = EN_NONE;
                    state_d = HALT;
                end else if (mem_stall) begin
                    en      = EN_NONE;
                    state_d = MEM_WAIT;
                end else begin
                    apply_rules = 1'b1;
                    mul_allowed = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (hz.wb_halt) begin
                    en      = EN_NONE;
                    state_d = HALT;
                end else if (!hz.mem_ready) begin
                    en = EN_NONE;
                end else begin
                    state_d     = RUN;
                    apply_rules = 1'b1;
                    mul_allowed = 1'b1;
                end
            end
            MUL_BUSY: begin
                // WB keeps draining while EX is held, so a halting instruction can
                // still arrive there; it wins over the multiplier.
                if (hz.wb_halt) begin
                    en      = EN_NONE;
                    state_d = HALT;
                end else if (mem_stall) begin
                    en = EN_NONE;
                end else if (mul_cnt_q != '0) begin
                    en        = EN_MUL;
                    ex_bubble = 1'b1;
                    mul_cnt_d = mul_cnt_q - 1'b1;
                end else begin
                    // Release cycle: the multiply still sitting in EX must not re-trigger.
                    state_d     = RUN;
                    apply_rules = 1'b1;
                end
            end
            default: begin
                en = EN_NONE;
            end
        endcase

        if (apply_rules) begin
            if (mul_allowed && hz.ex_mul_start && MUL_STALLS) begin
                en        = EN_MUL;
                ex_bubble = 1'b1;
                mul_cnt_d = MUL_INIT;
                state_d   = MUL_BUSY;
            end else if (hz.ex_take_branch) begin
                // The load-use request comes from a wrong-path instruction; drop it.
                sel_target = 1'b1;
                flush      = 1'b1;
                id_bubble  = 1'b1;
            end else if (hz.d_hazard_detected) begin
                en        = EN_LDU;
                id_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    // Reset forces every control low, independent of the clock.
    assign hz.pc_en         = rst & en.pc;
    assign hz.if_id_en      = rst & en.if_id;
    assign hz.id_ex_en      = rst & en.id_ex;
    assign hz.ex_mem_en     = rst & en.ex_mem;
    assign hz.mem_wb_en     = rst & en.mem_wb;
    assign hz.pc_sel_target = rst & sel_target;
    assign hz.if_id_flush   = rst & flush;
    assign hz.id_ex_bubble  = rst & id_bubble;
    assign hz.ex_mem_bubble = rst & ex_bubble;
    assign hz.halted        = (state_q == HALT);

    logic stall_inc;
    assign stall_inc = !hz.pc_en && (state_q != HALT);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .inc_i   (stall_inc),
        .count_o (hz.stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .inc_i   (hz.if_id_flush),
        .count_o (hz.flush_cnt)
    );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose: scoreboard bench for pipe_hazard_ctrl; driver pushes model expectations, monitor compares.
// Latency: expectations are per-cycle (combinational controls, counters one clock behind).
// Backpressure: n/a.
module tb_pipe_hazard_ctrl;
    localparam int ML    = 4;
    localparam int CW    = 6;
    localparam int CMAX  = (1 << CW) - 1;

    typedef struct packed {
        logic pc_en;
        logic pc_sel_target;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_mem_bubble;
        logic halted;
    } out_t;

    typedef struct {
        int   cyc;
        out_t o;
        int   stall;
        int   flush;
    } exp_t;

    logic clk;
    logic rst;
    pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(.MUL_LATENCY(ML), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: pipeline condition described as "halted", "waiting on memory"
    // and "multiply in flight with N front-end stall cycles still owed".
    bit m_halted;
    bit m_memwait;
    bit m_mul_active;
    int m_mul_owed;
    int m_stall;
    int m_flush;

    task automatic step(input logic r, input logic ldu, input logic br, input logic mul,
                        input logic mreq, input logic mrdy, input logic halt);
        logic [4:0] en;   // pc, if_id, id_ex, ex_mem, mem_wb
        logic sel, fl, idb, exb, was_halted, fresh;
        exp_t e;
        @(posedge clk);
        #1;
        rst                   = r;
        bus.d_hazard_detected = ldu;
        bus.ex_take_branch    = br;
        bus.ex_mul_start      = mul;
        bus.mem_req           = mreq;
        bus.mem_ready         = mrdy;
        bus.wb_halt           = halt;
        cyc++;

        en = 5'b11111; sel = 0; fl = 0; idb = 0; exb = 0;
        was_halted = m_halted;
        if (!r) begin
            en = 5'b00000;
            m_halted = 0; m_memwait = 0; m_mul_active = 0; m_mul_owed = 0;
            m_stall = 0; m_flush = 0;
            was_halted = 0;
        end else if (m_halted) begin
            en = 5'b00000;
        end else if (halt) begin
            en = 5'b00000;
            m_halted = 1;
        end else if (m_memwait ? !mrdy : (mreq && !mrdy)) begin
            en = 5'b00000;
            if (!m_mul_active) m_memwait = 1;
        end else begin
            m_memwait = 0;
            if (m_mul_active && m_mul_owed > 0) begin
                en = 5'b00011; exb = 1;
                m_mul_owed--;
            end else begin
                fresh = !m_mul_active;
                m_mul_active = 0;
                if (fresh && mul && ML > 1) begin
                    en = 5'b00011; exb = 1;
                    m_mul_active = 1;
                    m_mul_owed = ML - 2;
                end else if (br) begin
                    sel = 1; fl = 1; idb = 1;
                end else if (ldu) begin
                    en = 5'b00111; idb = 1;
                end
            end
        end

        e.cyc = cyc;
        e.o.pc_en = en[4]; e.o.if_id_en = en[3]; e.o.id_ex_en = en[2];
        e.o.ex_mem_en = en[1]; e.o.mem_wb_en = en[0];
        e.o.pc_sel_target = sel; e.o.if_id_flush = fl;
        e.o.id_ex_bubble = idb; e.o.ex_mem_bubble = exb;
        e.o.halted = was_halted;
        e.stall = m_stall;
        e.flush = m_flush;
        q.push_back(e);

        if (r) begin
            if (!en[4] && !was_halted && m_stall < CMAX) m_stall++;
            if (fl && m_flush < CMAX) m_flush++;
        end
    endtask

    // Monitor: one entry per driven cycle, compared at the falling edge.
    initial begin
        exp_t e;
        out_t a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a.pc_en = bus.pc_en; a.pc_sel_target = bus.pc_sel_target;
                a.if_id_en = bus.if_id_en; a.id_ex_en = bus.id_ex_en;
                a.ex_mem_en = bus.ex_mem_en; a.mem_wb_en = bus.mem_wb_en;
                a.if_id_flush = bus.if_id_flush; a.id_ex_bubble = bus.id_ex_bubble;
                a.ex_mem_bubble = bus.ex_mem_bubble; a.halted = bus.halted;
                checks++;
                if (a !== e.o) begin
                    errors++;
                    $display("FAIL ctrl cycle %0d: got %b want %b (pc,sel,ifid,idex,exmem,memwb,flush,idb,exb,halt)",
                             e.cyc, a, e.o);
                end
                checks++;
                if (bus.stall_cnt !== CW'(e.stall)) begin
                    errors++;
                    $display("FAIL stall_cnt cycle %0d: got %0d want %0d", e.cyc, bus.stall_cnt, e.stall);
                end
                checks++;
                if (bus.flush_cnt !== CW'(e.flush)) begin
                    errors++;
                    $display("FAIL flush_cnt cycle %0d: got %0d want %0d", e.cyc, bus.flush_cnt, e.flush);
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        rst = 1'b0;
        bus.d_hazard_detected = 0; bus.ex_take_branch = 0; bus.ex_mul_start = 0;
        bus.mem_req = 0; bus.mem_ready = 0; bus.wb_halt = 0;

        // rst, ldu, br, mul, mreq, mrdy, halt
        repeat (2) step(0, 0, 0, 0, 0, 0, 0);
        repeat (5) step(1, 0, 0, 0, 0, 0, 0);
        // load-use
        step(1, 1, 0, 0, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0, 0, 0);
        // MUL held across its whole occupancy
        repeat (4) step(1, 0, 0, 1, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0, 0, 0);
        // memory wait 4 cycles then release
        repeat (4) step(1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        // MUL interrupted by a memory wait: occupancy must hold
        step(1, 0, 0, 1, 0, 0, 0);
        repeat (3) step(1, 0, 0, 1, 1, 0, 0);
        step(1, 0, 0, 1, 1, 1, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0, 0);
        // memory wait released into a MUL issue
        repeat (2) step(1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 1, 0);
        repeat (4) step(1, 0, 0, 0, 0, 0, 0);
        // branch and load-use together
        step(1, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        // halt, hold, then reset mid-halt
        step(1, 0, 0, 0, 0, 0, 1);
        repeat (10) step(1, 0, 0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0, 0);

        // Random traffic, with occasional halts and resets (including mid-stall).
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) >= 2),
                 ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 99) < 35),
                 ($urandom_range(0, 99) < 55),
                 ($urandom_range(0, 99) < 1));
        end

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            #1;
            wait_cyc++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
